// File: rtl/console_pkg.sv
// console_pkg: shared geometry defaults, keyboard codes and the
// state encoding of the clear/scroll engine.
package console_pkg;

  localparam int COLS_DEF = 70;
  localparam int ROWS_DEF = 30;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCROLL_RD = 3'd1,
    ST_SCROLL_WR = 3'd2,
    ST_CLR_ROW   = 3'd3,
    ST_CLR_ALL   = 3'd4
  } state_e;

  function automatic logic is_printable(input logic [7:0] k);
    return (k >= ASCII_SP) && (k <= ASCII_TILDE);
  endfunction

endpackage

// File: rtl/console_fill_engine.sv
// console_fill_engine: walks the character buffer one cell per step for
// the clear-screen and scroll operations. A scroll copies rows up with a
// read cycle followed by a write cycle per cell, then blanks the last row.
// The scroll states are only entered when the top-level build enables
// scrolling (CONSOLE_SCROLL_EN); otherwise i_start_scroll is tied low.
module console_fill_engine
  import console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start_scroll,
  input  logic        i_start_clr,
  input  logic [7:0]  i_rd_data,
  output state_e      o_state,
  output logic        o_done,
  output logic [11:0] o_rd_addr,
  output logic        o_wr_en,
  output logic [11:0] o_wr_addr,
  output logic [7:0]  o_wr_data
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  // Last destination row of the copy pass; the row below it is blanked.
  localparam logic [4:0] LAST_DST = 5'(ROWS - 2);

  state_e     r_state;
  state_e     w_nx_state;
  logic [6:0] r_col;
  logic [6:0] w_nx_col;
  logic [4:0] r_row;
  logic [4:0] w_nx_row;
  logic       w_last_col;
  logic [4:0] w_row_p1;

  assign w_last_col = (r_col == LAST_COL);
  assign w_row_p1   = r_row + 5'd1;
  assign o_state    = r_state;

  // State register and cell counters; reset abandons any walk in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_nx_state;
      r_col   <= w_nx_col;
      r_row   <= w_nx_row;
    end
  end

  // Next state, cell walk and buffer-port drive.
  always_comb begin
    w_nx_state = r_state;
    w_nx_col   = r_col;
    w_nx_row   = r_row;
    o_done     = 1'b0;
    o_rd_addr  = '0;
    o_wr_en    = 1'b0;
    o_wr_addr  = '0;
    o_wr_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start_clr) begin
          w_nx_state = ST_CLR_ALL;
          w_nx_col   = '0;
          w_nx_row   = '0;
        end else if (i_start_scroll) begin
          w_nx_state = ST_SCROLL_RD;
          w_nx_col   = '0;
          w_nx_row   = '0;
        end
      end
      ST_SCROLL_RD: begin
        // Fetch the cell one row below the destination.
        o_rd_addr  = {r_col, w_row_p1};
        w_nx_state = ST_SCROLL_WR;
      end
      ST_SCROLL_WR: begin
        // Buffer read data has arrived; store it one row up.
        o_wr_en    = 1'b1;
        o_wr_addr  = {r_col, r_row};
        o_wr_data  = i_rd_data;
        w_nx_state = ST_SCROLL_RD;
        if (w_last_col) begin
          w_nx_col = '0;
          w_nx_row = w_row_p1;
          if (r_row == LAST_DST) begin
            w_nx_state = ST_CLR_ROW;
          end
        end else begin
          w_nx_col = r_col + 7'd1;
        end
      end
      ST_CLR_ROW: begin
        o_wr_en   = 1'b1;
        o_wr_addr = {r_col, r_row};
        if (w_last_col) begin
          w_nx_state = ST_IDLE;
          w_nx_col   = '0;
          w_nx_row   = '0;
          o_done     = 1'b1;
        end else begin
          w_nx_col = r_col + 7'd1;
        end
      end
      ST_CLR_ALL: begin
        o_wr_en   = 1'b1;
        o_wr_addr = {r_col, r_row};
        if (w_last_col) begin
          w_nx_col = '0;
          if (r_row == LAST_ROW) begin
            w_nx_state = ST_IDLE;
            w_nx_row   = '0;
            o_done     = 1'b1;
          end else begin
            w_nx_row = w_row_p1;
          end
        end else begin
          w_nx_col = r_col + 7'd1;
        end
      end
      default: begin
        w_nx_state = ST_IDLE;
        w_nx_col   = '0;
        w_nx_row   = '0;
      end
    endcase
  end

endmodule

// File: rtl/console_ctrl.sv
// console_ctrl: text console controller. Decodes keyboard codes, keeps the
// cursor, writes characters into an external character buffer and hands
// clear-screen and scroll work to console_fill_engine. A one-entry pending
// buffer absorbs keys that arrive while the engine is busy.
// Build option: define CONSOLE_SCROLL_EN to scroll the screen on a newline
// from the last row; without it the cursor wraps to (0,0) instead.
module console_ctrl
  import console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key_in,
  input  logic        p_valid,
  output logic [11:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy,
  output logic        overflow
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic [6:0]  r_cur_x;
  logic [4:0]  r_cur_y;
  logic        r_pend_vld;
  logic [7:0]  r_pend_key;
  logic        r_ovf;
  logic        r_kwr_en;
  logic [11:0] r_kwr_addr;
  logic [7:0]  r_kwr_data;

  state_e      w_state;
  logic        w_done;
  logic        w_idle;
  logic        w_take;
  logic [7:0]  w_key;
  logic [6:0]  w_nx_x;
  logic [4:0]  w_nx_y;
  logic        w_nl;
  logic        w_kwr;
  logic [11:0] w_kwr_addr;
  logic [7:0]  w_kwr_data;
  logic        w_start_clr;
  logic        w_start_scroll;
  logic [6:0]  w_x_m1;
  logic [4:0]  w_y_m1;
  logic [4:0]  w_y_p1;
  logic        w_eng_wr_en;
  logic [11:0] w_eng_wr_addr;
  logic [7:0]  w_eng_wr_data;

  assign w_idle = (w_state == ST_IDLE);
  // A pending key always goes before a newly arriving one.
  assign w_take = w_idle & (r_pend_vld | p_valid);
  assign w_key  = r_pend_vld ? r_pend_key : key_in;
  assign w_x_m1 = r_cur_x - 7'd1;
  assign w_y_m1 = r_cur_y - 5'd1;
  assign w_y_p1 = r_cur_y + 5'd1;

  // Key decode: next cursor, character/erase write and engine start.
  always_comb begin
    w_nx_x         = r_cur_x;
    w_nx_y         = r_cur_y;
    w_nl           = 1'b0;
    w_kwr          = 1'b0;
    w_kwr_addr     = {r_cur_x, r_cur_y};
    w_kwr_data     = w_key;
    w_start_clr    = 1'b0;
    w_start_scroll = 1'b0;
    if (w_take) begin
      if (is_printable(w_key)) begin
        w_kwr = 1'b1;
        if (r_cur_x == LAST_COL) begin
          w_nl = 1'b1;
        end else begin
          w_nx_x = r_cur_x + 7'd1;
        end
      end else if (w_key == ASCII_LF) begin
        w_nl = 1'b1;
      end else if (w_key == ASCII_BS) begin
        if (r_cur_x != '0) begin
          w_nx_x     = w_x_m1;
          w_kwr      = 1'b1;
          w_kwr_addr = {w_x_m1, r_cur_y};
          w_kwr_data = '0;
        end else if (r_cur_y != '0) begin
          w_nx_x     = LAST_COL;
          w_nx_y     = w_y_m1;
          w_kwr      = 1'b1;
          w_kwr_addr = {LAST_COL, w_y_m1};
          w_kwr_data = '0;
        end
      end else if (w_key == ASCII_FF) begin
        w_start_clr = 1'b1;
      end
      if (w_nl) begin
        if (r_cur_y != LAST_ROW) begin
          w_nx_x = '0;
          w_nx_y = w_y_p1;
        end else begin
`ifdef CONSOLE_SCROLL_EN
          // Cursor stays put until the scroll finishes.
          w_start_scroll = 1'b1;
`else
          w_nx_x = '0;
          w_nx_y = '0;
`endif
        end
      end
    end
  end

  // Cursor: moves on accepted keys, parks when a clear or scroll completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else if (w_done) begin
      r_cur_x <= '0;
      r_cur_y <= (w_state == ST_CLR_ROW) ? LAST_ROW : 5'd0;
    end else begin
      r_cur_x <= w_nx_x;
      r_cur_y <= w_nx_y;
    end
  end

  // Pending buffer and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_vld <= 1'b0;
      r_pend_key <= '0;
      r_ovf      <= 1'b0;
    end else if (w_idle) begin
      // The pending key is consumed this cycle; a new strobe refills it.
      if (r_pend_vld) begin
        r_pend_vld <= p_valid;
        if (p_valid) begin
          r_pend_key <= key_in;
        end
      end
    end else if (p_valid) begin
      if (r_pend_vld) begin
        r_ovf <= 1'b1;
      end else begin
        r_pend_vld <= 1'b1;
        r_pend_key <= key_in;
      end
    end
  end

  // Registered character/erase write, presented the cycle after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kwr_en   <= 1'b0;
      r_kwr_addr <= '0;
      r_kwr_data <= '0;
    end else begin
      r_kwr_en <= w_kwr;
      if (w_kwr) begin
        r_kwr_addr <= w_kwr_addr;
        r_kwr_data <= w_kwr_data;
      end
    end
  end

  console_fill_engine #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_fill (
    .clk            (clk),
    .reset          (reset),
    .i_start_scroll (w_start_scroll),
    .i_start_clr    (w_start_clr),
    .i_rd_data      (rd_data),
    .o_state        (w_state),
    .o_done         (w_done),
    .o_rd_addr      (rd_addr),
    .o_wr_en        (w_eng_wr_en),
    .o_wr_addr      (w_eng_wr_addr),
    .o_wr_data      (w_eng_wr_data)
  );

  // A key write that launches a scroll lands in the first SCROLL_RD cycle,
  // where the engine itself never writes, so the two never collide.
  assign wr_en    = r_kwr_en | w_eng_wr_en;
  assign wr_addr  = r_kwr_en ? r_kwr_addr : w_eng_wr_addr;
  assign wr_data  = r_kwr_en ? r_kwr_data : w_eng_wr_data;
  assign cur_x    = r_cur_x;
  assign cur_y    = r_cur_y;
  assign busy     = ~w_idle;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_console_ctrl.sv
// tb_console_ctrl: directed and randomized key sequences against a
// screen-level reference model (2-D character image plus cursor).
module tb_console_ctrl;

  localparam int COLS = 70;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  key_in;
  logic        p_valid;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;
  logic        overflow;

  logic [7:0]  mem    [4096];
  logic [7:0]  pl_img [4096];
  logic        pl_en = 1'b0;
  logic [7:0]  scr    [4096];
  int          mx, my, m_busy, m_wr;
  int          total, bad, wr_cnt;
  logic [11:0] last_wa;
  logic [7:0]  last_wd;
  logic [7:0]  others [8] = '{8'h00, 8'h07, 8'h09, 8'h0D, 8'h1B, 8'h7F, 8'h80, 8'hFF};

  console_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_in   (key_in),
    .p_valid  (p_valid),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Character buffer: synchronous write, one-cycle read latency, bulk image load.
  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pl_img[i];
    end else if (wr_en === 1'b1) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  // Write counter and last-write capture.
  always @(posedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= wr_addr;
      last_wd <= wr_data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] ad(input int x, input int y);
    return {x[6:0], y[4:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: newline, scrolling the whole image up when on the last row.
  task automatic model_nl();
    if (my < ROWS - 1) begin
      mx = 0;
      my++;
    end else begin
`ifdef CONSOLE_SCROLL_EN
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[ad(c, r)] = scr[ad(c, r + 1)];
      for (int c = 0; c < COLS; c++) scr[ad(c, ROWS - 1)] = 8'h00;
      mx = 0;
      my = ROWS - 1;
      m_busy = 2 * COLS * (ROWS - 1) + COLS;
      m_wr += COLS * ROWS;
`else
      mx = 0;
      my = 0;
`endif
    end
  endtask

  // Reference: effect of one key on image, cursor, busy time and write count.
  task automatic model_key(input logic [7:0] k);
    m_busy = 0;
    m_wr   = 0;
    if (k >= 8'h20 && k <= 8'h7E) begin
      scr[ad(mx, my)] = k;
      m_wr = 1;
      if (mx == COLS - 1) model_nl();
      else mx++;
    end else if (k == 8'h0A) begin
      model_nl();
    end else if (k == 8'h08) begin
      if (mx > 0) begin
        mx--;
        scr[ad(mx, my)] = 8'h00;
        m_wr = 1;
      end else if (my > 0) begin
        mx = COLS - 1;
        my--;
        scr[ad(mx, my)] = 8'h00;
        m_wr = 1;
      end
    end else if (k == 8'h0C) begin
      for (int i = 0; i < 4096; i++) scr[i] = 8'h00;
      mx = 0;
      my = 0;
      m_busy = COLS * ROWS;
      m_wr = COLS * ROWS;
    end
  endtask

  task automatic pulse(input logic [7:0] k);
    @(negedge clk);
    key_in  = k;
    p_valid = 1'b1;
    @(negedge clk);
    p_valid = 1'b0;
  endtask

  task automatic press(input logic [7:0] k);
    pulse(k);
    model_key(k);
  endtask

  task automatic wait_idle(input int lim, output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_key(input logic [7:0] k);
    int c0;
    int cyc;
    c0 = wr_cnt;
    press(k);
    wait_idle(6000, cyc);
    @(negedge clk);
    chk("busy_cycles", cyc, m_busy);
    chk("write_count", wr_cnt - c0, m_wr);
    chk("cur_x", cur_x, mx);
    chk("cur_y", cur_y, my);
    chk("rd_addr_idle", rd_addr, 0);
  endtask

  task automatic preload();
    for (int i = 0; i < 4096; i++) pl_img[i] = scr[i];
    @(negedge clk);
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic chk_screen(input string tag);
    int n;
    n = 0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (mem[ad(c, r)] !== scr[ad(c, r)]) n++;
    chk(tag, n, 0);
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 8'($urandom_range(32, 126));
    if (r < 82) return 8'h0A;
    if (r < 92) return 8'h08;
    return others[$urandom_range(0, 7)];
  endfunction

  initial begin
    int c0;
    int cyc;
    reset   = 1'b0;
    key_in  = 8'h00;
    p_valid = 1'b0;
    for (int i = 0; i < 4096; i++) scr[i] = 8'h00;
    mx = 0;
    my = 0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_cursor", {cur_x, cur_y}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    preload();
    reset = 1'b1;
    @(negedge clk);

    // First printable key: single write at the origin.
    c0 = wr_cnt;
    press(8'h41);
    chk("k41_wr_en", wr_en, 1);
    chk("k41_wr_addr", wr_addr, 12'h000);
    chk("k41_wr_data", wr_data, 8'h41);
    @(negedge clk);
    chk("k41_wr_once", wr_en, 0);
    chk("k41_cur_x", cur_x, 1);
    chk("k41_cur_y", cur_y, 0);
    chk("k41_count", wr_cnt - c0, 1);

    // Clear screen.
    do_key(8'h0C);
    chk_screen("clr_screen");

    // A full row of 0x42 wraps to the next row.
    for (int i = 0; i < COLS; i++) do_key(8'h42);
    chk("row_last_addr", last_wa, ad(69, 0));
    chk("row_last_data", last_wd, 8'h42);
    chk("row_cursor", {cur_x, cur_y}, {7'd0, 5'd1});

    // Backspace across a row boundary, then at the origin.
    do_key(8'h0A);
    do_key(8'h0A);
    do_key(8'h08);
    chk("bs_wrap_addr", last_wa, ad(69, 2));
    chk("bs_wrap_data", last_wd, 8'h00);
    chk("bs_wrap_cursor", {cur_x, cur_y}, {7'd69, 5'd2});
    do_key(8'h0C);
    c0 = wr_cnt;
    do_key(8'h08);
    chk("bs_origin_nowrite", wr_cnt - c0, 0);
    chk_screen("bs_screen");

    // Random key mix.
    for (int i = 0; i < 200; i++) do_key(rand_key());
    chk_screen("rand_screen");

    // Newline on the last row over a random image.
    do_key(8'h0C);
    for (int i = 0; i < ROWS - 1; i++) do_key(8'h0A);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) scr[ad(c, r)] = 8'($urandom_range(0, 255));
    preload();
    c0 = wr_cnt;
    do_key(8'h0A);
`ifdef CONSOLE_SCROLL_EN
    chk("scroll_cursor", {cur_x, cur_y}, {7'd0, 5'd29});
    chk("scroll_busy", cyc_dummy(), 0);
`else
    chk("wrap_cursor", {cur_x, cur_y}, 0);
    chk("wrap_nowrite", wr_cnt - c0, 0);
`endif
    chk_screen("scroll_screen");
    for (int i = 0; i < COLS; i++) do_key(8'($urandom_range(32, 126)));
    chk_screen("lastcol_screen");

    // Keys arriving during a clear: first buffered, rest dropped.
    c0 = wr_cnt;
    press(8'h0C);
    repeat (10) @(negedge clk);
    pulse(8'h51);
    repeat (10) @(negedge clk);
    pulse(8'h52);
    repeat (10) @(negedge clk);
    pulse(8'h53);
    wait_idle(6000, cyc);
    chk("pend_overflow", overflow, 1);
    @(negedge clk);
    chk("pend_wr_en", wr_en, 1);
    chk("pend_wr_addr", wr_addr, 12'h000);
    chk("pend_wr_data", wr_data, 8'h51);
    model_key(8'h51);
    @(negedge clk);
    chk("pend_cursor", {cur_x, cur_y}, {7'(mx), 5'(my)});
    chk("pend_count", wr_cnt - c0, COLS * ROWS + 1);
    chk_screen("pend_screen");

    // Reset in the middle of a scroll (or of the wrap when scrolling is off).
    for (int i = 0; i < ROWS - 1; i++) do_key(8'h0A);
    pulse(8'h0A);
    repeat (100) @(negedge clk);
`ifdef CONSOLE_SCROLL_EN
    chk("midscroll_busy", busy, 1);
`endif
    #2;
    reset = 1'b0;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_rd_addr", rd_addr, 0);
    chk("arst_cursor", {cur_x, cur_y}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    mx = 0;
    my = 0;
    @(negedge clk);
    press(8'h41);
    chk("post_rst_wr_en", wr_en, 1);
    chk("post_rst_wr_addr", wr_addr, 12'h000);
    chk("post_rst_wr_data", wr_data, 8'h41);
    @(negedge clk);
    chk("post_rst_cursor", {cur_x, cur_y}, {7'd1, 5'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Busy must be low once a scroll has been waited out.
  function automatic logic [31:0] cyc_dummy();
    return {31'd0, busy};
  endfunction

endmodule

// File: doc/console_ctrl.md
CONSOLE_CTRL -- requirements
Module: console_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 70, characters per row.
REQ-002 SHALL have parameter ROWS, default 30, text rows per screen.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key_in  input  8  ASCII code from keyboard decoder.
REQ-006 SHALL have port p_valid  input  1  one-cycle strobe qualifying key_in.
REQ-007 SHALL have port rd_addr  output  12  character-buffer read address {x[6:0],y[4:0]}.
REQ-008 SHALL have port rd_data  input  8  buffer read data, valid one cycle after rd_addr.
REQ-009 SHALL have port wr_en  output  1  buffer write strobe.
REQ-010 SHALL have port wr_addr  output  12  buffer write address {x[6:0],y[4:0]}.
REQ-011 SHALL have port wr_data  output  8  buffer write data.
REQ-012 SHALL have ports cur_x  output  7 and cur_y  output  5  cursor column and row.
REQ-013 SHALL have port busy  output  1  clear/scroll engine active.
REQ-014 SHALL have port overflow  output  1  sticky key-drop flag.

Function
REQ-015 SHALL decode keys: 0x20-0x7E printable; 0x0A newline; 0x08 backspace; 0x0C clear-screen; all other codes are consumed with no effect.
REQ-016 SHALL, for a printable key in IDLE, assert wr_en for exactly one cycle on the cycle after acceptance, with wr_addr={cur_x,cur_y} and wr_data=key, then advance the cursor on the same edge.
REQ-017 SHALL advance the cursor as x+1, or, when x==COLS-1, as for a newline.
REQ-018 SHALL handle a newline as x=0 and y+1 when y<ROWS-1, and as a scroll when y==ROWS-1.
REQ-019 SHALL handle a backspace as follows: at (0,0), ignore it; at x>0, move to (x-1,y) and write 0x00 there; at x==0 with y>0, move to (COLS-1,y-1) and write 0x00 there.
REQ-020 SHALL handle a clear-screen by writing 0x00 to all COLS*ROWS cells, one cell per cycle, column-major within a row and rows 0..ROWS-1 in order, then setting the cursor to (0,0).
REQ-021 SHALL scroll by copying every cell (c,r+1) to (c,r) for r=0..ROWS-2 and c=0..COLS-1, using 2 cycles per cell (SCROLL_RD drives rd_addr, SCROLL_WR writes rd_data), then zero row ROWS-1 in COLS cycles, then set the cursor to (0,ROWS-1).
REQ-022 SHALL use FSM states IDLE, SCROLL_RD, SCROLL_WR, CLR_ROW and CLR_ALL, with transitions: IDLE->SCROLL_RD on scroll; SCROLL_RD<->SCROLL_WR until the last copy; ->CLR_ROW; ->IDLE; IDLE->CLR_ALL on 0x0C; CLR_ALL->IDLE after the last cell.
REQ-023 SHALL assert busy in every state except IDLE.
REQ-024 SHALL hold cur_x and cur_y constant while busy.
REQ-025 SHALL hold a one-entry pending buffer: a p_valid arriving while busy, or while a key is already being processed, is stored there.
REQ-026 SHALL, on p_valid with the pending buffer already full, drop the key and set overflow, which stays high until reset.
REQ-027 SHALL, in IDLE with the pending buffer full, process the pending key first; a simultaneous p_valid then fills the freed entry.
REQ-028 SHALL never issue wr_en for two different addresses in the same cycle, and SHALL keep rd_addr at 0 outside SCROLL_RD.

Reset
REQ-029 SHALL, on reset low and regardless of clock, force IDLE, cur_x=0, cur_y=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, overflow=0 and the pending buffer empty.
REQ-030 SHALL abandon any scroll or clear in progress on reset, without completing it and without clearing the buffer contents.

Configuration
REQ-031 SHALL, with CONSOLE_SCROLL_EN defined, implement scrolling per REQ-018/REQ-021.
REQ-032 SHALL, without CONSOLE_SCROLL_EN, replace a scroll with a cursor move to (0,0) and no buffer writes; SCROLL_RD, SCROLL_WR and CLR_ROW then SHALL be unreachable and may be removed.

Structure
REQ-033 SHALL place the default COLS/ROWS, the ASCII constants (0x08, 0x0A, 0x0C, 0x20, 0x7E) and the FSM state encoding in shared package console_pkg.
REQ-034 SHALL implement the cell-iterating scroll/clear address generator as sub-module console_fill_engine; key decoding, the cursor and the pending buffer SHALL stay in console_ctrl.

Verification
REQ-035 SHALL verify: release reset; key 0x41 -> one wr_en, addr {0,0}, data 0x41; cursor (1,0).
REQ-036 SHALL verify: 70 keys 0x42 from (0,0) -> last write at {69,0}; cursor (0,1).
REQ-037 SHALL verify: backspace at (0,3) -> write 0x00 at {69,2}; cursor (69,2); backspace at (0,0) -> no wr_en.
REQ-038 SHALL verify: newline at row 29 with macro defined -> busy for 2*70*29+70=4130 cycles, row r holds old row r+1, row 29 is all 0x00, cursor (0,29); without the macro -> cursor (0,0), no writes.
REQ-039 SHALL verify: three p_valid pulses during CLR_ALL -> first key is buffered and written after busy falls, the rest are dropped, overflow=1.
REQ-040 SHALL verify: reset asserted mid-scroll -> all outputs 0 asynchronously; the next key writes at {0,0}.
